btn_conditioner: RTL
====================

# btn_conditioner

Two-channel input conditioner that sits directly upstream of the two-input Moore/Mealy lab FSM (inputs `A`, `B`). Each channel takes a raw, asynchronous push-button level, synchronises it into the `clck` domain, and debounces it. It then drives the FSM input either as a clean debounced level or as a one-cycle press pulse. The two channels are identical and fully independent.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable synchronised samples required to accept a new level. Legal range is 1 .. 2^`CNT_W`−1.
- `CNT_W`, default 8: width of each per-channel debounce counter.

- `clck` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset is synchronous and active-high. It is sampled on the rising edge of `clck` and clears all state.
- `a_raw` input 1: raw button A, asynchronous to `clck`.
- `b_raw` input 1: raw button B, asynchronous to `clck`.
- `A` output 1: conditioned channel A; feeds the FSM input `A`.
- `B` output 1: conditioned channel B; feeds the FSM input `B`.

## Operation
Per channel (shown for A; B is identical):
- **Synchroniser**: two flops, `s1 <= a_raw` and `s2 <= s1`. Only `s2` is used downstream.
- **Debounce state**: `stable` (accepted level) and `cnt` (`CNT_W` bits). On each edge:
  - If `s2 == stable`: `cnt <= 0`.
  - Else if `cnt == DEB_CYCLES-1`: `stable <= s2` and `cnt <= 0` (this is the "accept" event).
  - Else: `cnt <= cnt+1`.
- **Glitch rejection**: if `s2` returns to `stable` before the accept event, `cnt` clears. A later change restarts counting from 0; partial counts never accumulate.
- **Output**: `A` is selected by configuration (see below) and is always a registered output.
- **Reset**:
  - `s1`, `s2`, `stable`, `cnt`, `A`, `B` all become 0.
  - `rst` has priority over every other update on that edge.
  - Asserting `rst` mid-count abandons the count.
- **Button held across reset**: after `rst` deasserts, it is treated as a fresh 0→1 change. It is accepted after the normal latency and, in pulse mode, produces one pulse.
- **Simultaneous events**: A and B changing on the same edge are processed independently. Both outputs may assert on the same edge.
- **Counter width**: `cnt` never exceeds `DEB_CYCLES-1`, so there is no wrap-around.

## Timing
- Counting the first rising edge that samples a new `a_raw` value as edge 1:
  - `s2` reflects the new value after edge 2.
  - The accept event happens on edge `DEB_CYCLES+2`.
  - Latency is `DEB_CYCLES+2` clocks (6 at the default).
- A raw change that persists for fewer than `DEB_CYCLES+1` edges in `s2` is never accepted.
- Release (1→0) uses the same latency as press.
- The first edge after `rst` deasserts is edge 1 for any level already present on `a_raw`.
- No combinational path exists from `a_raw`/`b_raw` to `A`/`B`.

## Configuration
- Macro: `BTN_PULSE_EN`.
- **Defined (pulse mode)**:
  - `A` asserts for exactly one clock, on the accept edge of a 0→1 transition of `stable`.
  - `A` is 0 at all other times, including on 1→0 accepts.
  - Holding the button yields a single pulse.
- **Undefined (level mode)**: `A` equals `stable`. It rises on a 0→1 accept and falls on a 1→0 accept, each with `DEB_CYCLES+2` latency.

## Test plan
All scenarios use `DEB_CYCLES=4`, run in both configurations unless noted.
1. **Reset values**: hold `rst=1` for 3 clocks with `a_raw=b_raw=1`. Required: `A=B=0` throughout; after release, `A`/`B` first change at edge 6.
2. **Clean press, level mode**: `a_raw` 0→1 and held 20 clocks. Required: `A=1` from edge 6 on and `B=0`; release gives `A=0` 6 clocks later.
3. **Clean press, pulse mode** (`BTN_PULSE_EN` defined): `a_raw` held high 20 clocks. Required: `A=1` for exactly one cycle at edge 6; no pulse on release.
4. **Bounce rejection**: `a_raw` high for 3 clocks, low 2, then high and held. Required: no accept from the 3-clock burst; `A` rises at edge 6 counted from the final rise.
5. **Simultaneous channels**: `a_raw` and `b_raw` rise on the same cycle. Required: `A` and `B` assert on the same edge (6).
6. **Reset mid-count**: `a_raw` rises; assert `rst` at edge 4 for 1 clock while `a_raw` stays high. Required: `A=0` through reset; `A` asserts 6 edges after `rst` release, and only once in pulse mode.

Source files
------------

// File: rtl/btn_conditioner_if.sv
// Raw button levels in, conditioned FSM inputs out.
// Shared by the conditioner (slave) and whatever drives the buttons (master).
interface btn_conditioner_if;
   logic a_raw;
   logic b_raw;
   logic A;
   logic B;

   modport master (
      output a_raw,
      output b_raw,
      input  A,
      input  B
   );

   modport slave (
      input  a_raw,
      input  b_raw,
      output A,
      output B
   );
endinterface

// File: rtl/btn_conditioner.sv
// Two-channel synchroniser + debouncer feeding the lab FSM inputs A/B.
// Define BTN_PULSE_EN for one-cycle press pulses; otherwise outputs are levels.
module btn_conditioner #(
   parameter int DEB_CYCLES = 4,
   parameter int CNT_W      = 8
) (
   input  logic         clck,
   input  logic         rst,
   btn_conditioner_if.slave io
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   logic [1:0]       raw;
   logic [1:0]       s1_q, s1_d;
   logic [1:0]       s2_q, s2_d;
   logic [1:0]       stable_q, stable_d;
   logic [1:0]       out_q, out_d;
   logic [1:0]       accept;
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];

   assign raw = {io.b_raw, io.a_raw};

   always_comb begin
      s1_d     = raw;
      s2_d     = s1_q;
      stable_d = stable_q;
      accept   = '0;
      out_d    = '0;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               accept[i]   = 1'b1;
               stable_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
`ifdef BTN_PULSE_EN
         out_d[i] = accept[i] & s2_q[i];
`else
         out_d[i] = stable_d[i];
`endif
      end
   end

   always_ff @(posedge clck) begin
      if (rst) begin
         s1_q     <= '0;
         s2_q     <= '0;
         stable_q <= '0;
         out_q    <= '0;
         cnt_q    <= '{default: '0};
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         stable_q <= stable_d;
         out_q    <= out_d;
         cnt_q    <= cnt_d;
      end
   end

   assign io.A = out_q[0];
   assign io.B = out_q[1];

endmodule
